// File: rtl/game_pkg.sv
// Shared types and default constants for the game controller slice.
// No logic; only the state enumeration and parameter defaults.
// Optional PAUSE state exists only when GAME_CTRL_PAUSE_EN is defined.
package game_pkg;

  localparam int TICK_DIV_DEF = 833333;  // 60 Hz frame tick at 50 MHz
  localparam int SCORE_W_DEF  = 8;
  localparam int LIVES_DEF    = 3;
  localparam int LIVES_W_DEF  = 2;

  typedef enum logic [2:0] {
    ST_MENU      = 3'd0,
    ST_MENU_WAIT = 3'd1,
    ST_PLAY      = 3'd2,
    ST_DEAD      = 3'd3,
    ST_OVER      = 3'd4
`ifdef GAME_CTRL_PAUSE_EN
    , ST_PAUSE   = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/tick_divider.sv
// Frame counter: counts 0..DIV-1 while en is high, wraps, holds otherwise.
// Latency: tick is combinational, high while en and count == DIV-1.
// Backpressure: none; clr has priority over en.
// Ports: clk, resetn (sync, active-low), en (count), clr (zero the count),
//        tick (end-of-frame indication).
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: menu / play / dead / over, frame ticks, score, lives.
// Latency: startgame/game_over decode state directly; frame_tick, grav_flip,
//          score and lives are registered (update on the deciding edge).
// Backpressure: none; go/grav are level inputs, edges detected internally.
// Ports: clk, resetn (sync, active-low), go, grav, endgame in;
//        startgame, frame_tick, grav_flip, score, lives, game_over out.
// Build option: define GAME_CTRL_PAUSE_EN to add a PAUSE state toggled by go.
module game_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int SCORE_W  = SCORE_W_DEF,
  parameter int LIVES    = LIVES_DEF,
  parameter int LIVES_W  = LIVES_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               go,
  input  logic               grav,
  input  logic               endgame,
  output logic               startgame,
  output logic               frame_tick,
  output logic               grav_flip,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);

  state_t             state_q, state_d;
  logic               go_q, grav_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               frame_tick_q, frame_tick_d;
  logic               grav_flip_q, grav_flip_d;

  logic go_rise, grav_rise;
  logic div_en, div_clr, div_tick;

  assign go_rise   = go & ~go_q;
  assign grav_rise = grav & ~grav_q;

  // Counter runs in every PLAY cycle (including the one that ends the game);
  // it is zeroed only on a fresh start, so resuming from DEAD keeps the phase.
  assign div_en  = (state_q == ST_PLAY);
  assign div_clr = (state_q == ST_MENU_WAIT) && !go;

  tick_divider #(
    .DIV(TICK_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .resetn(resetn),
    .en    (div_en),
    .clr   (div_clr),
    .tick  (div_tick)
  );

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    lives_d      = lives_q;
    frame_tick_d = 1'b0;
    grav_flip_d  = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (go_rise) begin
          state_d = ST_MENU_WAIT;
          score_d = '0;
          lives_d = LIVES_W'(LIVES);
        end
      end
      ST_MENU_WAIT: begin
        if (!go) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        grav_flip_d = grav_rise;
        if (endgame) begin
          // Collision beats a coincident frame tick and any pause request.
          lives_d = lives_q - LIVES_W'(1);
          state_d = (lives_q == LIVES_W'(1)) ? ST_OVER : ST_DEAD;
        end else begin
          if (div_tick) begin
            frame_tick_d = 1'b1;
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
          end
`ifdef GAME_CTRL_PAUSE_EN
          if (go_rise) state_d = ST_PAUSE;
`endif
        end
      end
      ST_DEAD: begin
        if (go_rise) state_d = ST_PLAY;
      end
      ST_OVER: begin
        if (go_rise) state_d = ST_MENU;
      end
`ifdef GAME_CTRL_PAUSE_EN
      ST_PAUSE: begin
        if (go_rise) state_d = ST_PLAY;
      end
`endif
      default: state_d = ST_MENU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_MENU;
      go_q         <= 1'b0;
      grav_q       <= 1'b0;
      score_q      <= '0;
      lives_q      <= LIVES_W'(LIVES);
      frame_tick_q <= 1'b0;
      grav_flip_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      go_q         <= go;
      grav_q       <= grav;
      score_q      <= score_d;
      lives_q      <= lives_d;
      frame_tick_q <= frame_tick_d;
      grav_flip_q  <= grav_flip_d;
    end
  end

  assign startgame  = (state_q == ST_PLAY);
  assign game_over  = (state_q == ST_OVER);
  assign frame_tick = frame_tick_q;
  assign grav_flip  = grav_flip_q;
  assign score      = score_q;
  assign lives      = lives_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: cycle model of the game rules plus literal spot checks.
module tb_game_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int SCORE_W   = 4;
  localparam int LIVES     = 3;
  localparam int LIVES_W   = 2;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  localparam int M_MENU  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_PLAY  = 2;
  localparam int M_DEAD  = 3;
  localparam int M_OVER  = 4;
  localparam int M_PAUSE = 5;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               go = 1'b0;
  logic               grav = 1'b0;
  logic               endgame = 1'b0;
  logic               startgame, frame_tick, grav_flip, game_over;
  logic [SCORE_W-1:0] score;
  logic [LIVES_W-1:0] lives;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  game_ctrl #(
    .TICK_DIV(TICK_DIV),
    .SCORE_W (SCORE_W),
    .LIVES   (LIVES),
    .LIVES_W (LIVES_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .go        (go),
    .grav      (grav),
    .endgame   (endgame),
    .startgame (startgame),
    .frame_tick(frame_tick),
    .grav_flip (grav_flip),
    .score     (score),
    .lives     (lives),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: play_cycles counts PLAY cycles since the game started;
  // a frame ends on every TICK_DIV-th one.
  int m_st = M_MENU;
  int m_play_cycles = 0;
  int m_score = 0;
  int m_lives = LIVES;
  bit m_tick = 1'b0;
  bit m_flip = 1'b0;
  bit m_go_prev = 1'b0;
  bit m_grav_prev = 1'b0;

  always @(posedge clk) begin
    bit go_r, grav_r, frame_end;
    if (!resetn) begin
      m_st = M_MENU; m_play_cycles = 0; m_score = 0; m_lives = LIVES;
      m_tick = 0; m_flip = 0; m_go_prev = 0; m_grav_prev = 0;
    end else begin
      go_r   = go && !m_go_prev;
      grav_r = grav && !m_grav_prev;
      m_tick = 0;
      m_flip = 0;
      case (m_st)
        M_MENU: if (go_r) begin m_st = M_WAIT; m_score = 0; m_lives = LIVES; end
        M_WAIT: if (!go) begin m_st = M_PLAY; m_play_cycles = 0; end
        M_PLAY: begin
          m_flip = grav_r;
          frame_end = (m_play_cycles % TICK_DIV) == TICK_DIV - 1;
          m_play_cycles++;
          if (endgame) begin
            m_lives = m_lives - 1;
            m_st = (m_lives == 0) ? M_OVER : M_DEAD;
          end else begin
            if (frame_end) begin
              m_tick = 1;
              if (m_score < SCORE_MAX) m_score++;
            end
`ifdef GAME_CTRL_PAUSE_EN
            if (go_r) m_st = M_PAUSE;
`endif
          end
        end
        M_DEAD:  if (go_r) m_st = M_PLAY;
        M_OVER:  if (go_r) m_st = M_MENU;
        M_PAUSE: if (go_r) m_st = M_PLAY;
        default: m_st = M_MENU;
      endcase
      m_go_prev   = go;
      m_grav_prev = grav;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("startgame",  startgame,  (m_st == M_PLAY));
      chk("game_over",  game_over,  (m_st == M_OVER));
      chk("frame_tick", frame_tick, m_tick);
      chk("grav_flip",  grav_flip,  m_flip);
      chk("score",      score,      m_score);
      chk("lives",      lives,      m_lives);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_game();
    go = 1; cyc(1);  // MENU -> MENU_WAIT
    go = 0; cyc(1);  // MENU_WAIT -> PLAY, counter cleared
  endtask

  initial begin
    resetn = 0;
    cyc(1);
    chk_en = 1;
    cyc(1);
    chk("rst_startgame", startgame, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_tick", frame_tick, 0);
    resetn = 1;
    cyc(1);

    // Start and first frame tick 4 cycles after entering PLAY.
    start_game();
    chk("play_startgame", startgame, 1);
    cyc(3);
    chk("no_tick_yet", frame_tick, 0);
    cyc(1);
    chk("first_tick", frame_tick, 1);
    chk("first_score", score, 1);

    // 20 more frames: saturate at 15.
    cyc(80);
    chk("sat_score", score, 15);

    // Three collisions: DEAD, DEAD, OVER.
    endgame = 1; cyc(1); endgame = 0;
    chk("dead1_lives", lives, 2);
    chk("dead1_startgame", startgame, 0);
    go = 1; cyc(1); go = 0;
    endgame = 1; cyc(1); endgame = 0;
    chk("dead2_lives", lives, 1);
    chk("dead2_game_over", game_over, 0);
    go = 1; cyc(1); go = 0; cyc(1);
    endgame = 1; cyc(1); endgame = 0;
    chk("over_lives", lives, 0);
    chk("over_game_over", game_over, 1);
    chk("over_score_hold", score, 15);
    go = 1; cyc(1); go = 0;
    chk("menu_game_over", game_over, 0);
    chk("menu_startgame", startgame, 0);
    cyc(1);

    // Collision coincident with a frame tick.
    start_game();
    chk("new_game_score", score, 0);
    chk("new_game_lives", lives, 3);
    cyc(3);
    endgame = 1; cyc(1); endgame = 0;
    chk("coinc_tick", frame_tick, 0);
    chk("coinc_score", score, 0);
    chk("coinc_lives", lives, 2);

    // Gravity edge in PLAY: one pulse only.
    go = 1; cyc(1); go = 0;
    grav = 1; cyc(1);
    chk("grav_pulse", grav_flip, 1);
    cyc(1);
    chk("grav_once", grav_flip, 0);
    cyc(3);
    grav = 0; cyc(1);

    // Reset mid-game with score 7.
    resetn = 0; cyc(1); resetn = 1; cyc(1);
    start_game();
    cyc(28);
    chk("pre_rst_score", score, 7);
    resetn = 0; cyc(1); resetn = 1;
    chk("rst_mid_startgame", startgame, 0);
    chk("rst_mid_score", score, 0);
    chk("rst_mid_lives", lives, 3);
    chk("rst_mid_tick", frame_tick, 0);

    // Gravity in MENU: no pulse.
    grav = 1; cyc(1);
    chk("grav_menu", grav_flip, 0);
    cyc(1); grav = 0; cyc(1);

`ifdef GAME_CTRL_PAUSE_EN
    start_game();
    cyc(5);
    go = 1; cyc(1); go = 0;
    chk("pause_startgame", startgame, 0);
    endgame = 1;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      chk("pause_score", score, 1);
    end
    endgame = 0;
    chk("pause_lives", lives, 3);
    go = 1; cyc(1); go = 0;
    chk("resume_startgame", startgame, 1);
    cyc(4);
`endif

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
